// File: rtl/score_seg_display_pkg.sv
// Shared game/display definitions: state codes, segment constants, blink FSM states.
package score_seg_display_pkg;

  // Game FSM state codes (shared with game FSM, score counter, LED controller)
  localparam logic [2:0] BALL_R = 3'd0;
  localparam logic [2:0] BALL_L = 3'd1;
  localparam logic [2:0] WIN_R  = 3'd2;
  localparam logic [2:0] WIN_L  = 3'd3;
  localparam logic [2:0] PLAY   = 3'd4;
  localparam logic [2:0] INIT   = 3'd5;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BLINK_R = 2'd1,
    BLINK_L = 2'd2
  } blink_st_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } dec_t;

  // Score 0..15 to two decimal digits; tens is only ever 0 or 1
  function automatic dec_t to_dec(input logic [3:0] s);
    dec_t d;
    d.tens = (s >= 4'd10) ? 4'd1 : 4'd0;
    d.ones = (s >= 4'd10) ? (s - 4'd10) : s;
    return d;
  endfunction

endpackage

// File: rtl/score_seg_display_seg_decoder.sv
// Combinational digit -> active-low seven-segment pattern, dp always off.
module seg_decoder
  import score_seg_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Pattern lookup; blank wins over digit
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = 8'hC0;
        4'd1:    seg_o = 8'hF9;
        4'd2:    seg_o = 8'hA4;
        4'd3:    seg_o = 8'hB0;
        4'd4:    seg_o = 8'h99;
        4'd5:    seg_o = 8'h92;
        4'd6:    seg_o = 8'h82;
        4'd7:    seg_o = 8'hF8;
        4'd8:    seg_o = 8'h80;
        4'd9:    seg_o = 8'h90;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_seg_display.sv
// Multiplexed 4-digit scoreboard: left score on digits 3..2, right on 1..0,
// blinks the scorer's pair after a point, dashes while the game is in init.
module score_seg_display
  import score_seg_display_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int BLINK_COUNT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [3:0] score_r,
  input  logic [3:0] score_l,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TCW = $clog2(BLINK_COUNT + 1);
  localparam logic [SCW-1:0] SCAN_TC  = SCW'(SCAN_DIV - 1);
  localparam logic [BKW-1:0] BLINK_TC = BKW'(BLINK_DIV - 1);
  localparam logic [TCW-1:0] TOG_LAST = TCW'(BLINK_COUNT - 1);

  logic [SCW-1:0] scan_cnt_q;
  logic [1:0]     idx_q;
  logic [3:0]     shadow_r_q, shadow_l_q;
  logic [2:0]     prev_state_q;
  logic           tick;

  blink_st_e      blk_st_q, blk_st_d;
  logic [BKW-1:0] blk_cnt_q, blk_cnt_d;
  logic [TCW-1:0] tog_q, tog_d;
  logic           phase_q, phase_d;
  logic           win_edge_r, win_edge_l, blank_r, blank_l;

  logic [7:0]     seg_q, seg_d, dec_seg;
  logic [3:0]     an_q, an_d, digit;
  logic           digit_blank;
  dec_t           dec_l, dec_r;

  assign tick       = (scan_cnt_q == SCAN_TC);
  assign win_edge_r = (state == WIN_R) && (prev_state_q != WIN_R);
  assign win_edge_l = (state == WIN_L) && (prev_state_q != WIN_L);

  // Digit-slot timer and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
    end else if (tick) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCW'(1);
    end
  end

  // Scores are captured only at frame start so a frame never mixes old/new digits
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r_q   <= 4'd0;
      shadow_l_q   <= 4'd0;
      prev_state_q <= INIT;
    end else begin
      prev_state_q <= state;
      if (tick && idx_q == 2'd3) begin
        shadow_r_q <= score_r;
        shadow_l_q <= score_l;
      end
    end
  end

  // Blink FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_st_q  <= IDLE;
      blk_cnt_q <= '0;
      tog_q     <= '0;
      phase_q   <= 1'b0;
    end else begin
      blk_st_q  <= blk_st_d;
      blk_cnt_q <= blk_cnt_d;
      tog_q     <= tog_d;
      phase_q   <= phase_d;
    end
  end

  // Blink FSM next state: init aborts, any win edge restarts, else count half-periods
  always_comb begin
    blk_st_d  = blk_st_q;
    blk_cnt_d = blk_cnt_q;
    tog_d     = tog_q;
    phase_d   = phase_q;
    if (state == INIT || win_edge_r || win_edge_l) begin
      blk_st_d  = (state == INIT) ? IDLE : (win_edge_r ? BLINK_R : BLINK_L);
      blk_cnt_d = '0;
      tog_d     = '0;
      phase_d   = 1'b0;
    end else begin
      case (blk_st_q)
        BLINK_R, BLINK_L: begin
          if (blk_cnt_q == BLINK_TC) begin
            blk_cnt_d = '0;
            if (tog_q == TOG_LAST) begin
              blk_st_d = IDLE;
              tog_d    = '0;
              phase_d  = 1'b0;
            end else begin
              tog_d   = tog_q + TCW'(1);
              phase_d = ~phase_q;
            end
          end else begin
            blk_cnt_d = blk_cnt_q + BKW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Blink FSM outputs: which pair is dark this half-period
  always_comb begin
    blank_r = (blk_st_q == BLINK_R) && phase_q;
    blank_l = (blk_st_q == BLINK_L) && phase_q;
  end

  assign dec_l = to_dec(shadow_l_q);
  assign dec_r = to_dec(shadow_r_q);

  // Pick the digit for the current slot; tens digits suppress leading zero
  always_comb begin
    digit       = dec_r.ones;
    digit_blank = blank_r;
    case (idx_q)
      2'd3: begin digit = dec_l.tens; digit_blank = (dec_l.tens == 4'd0) || blank_l; end
      2'd2: begin digit = dec_l.ones; digit_blank = blank_l; end
      2'd1: begin digit = dec_r.tens; digit_blank = (dec_r.tens == 4'd0) || blank_r; end
      default: ;
    endcase
  end

  seg_decoder u_dec (
    .digit_i (digit),
    .blank_i (digit_blank),
    .seg_o   (dec_seg)
  );

  // Next output: dash in init, otherwise decoded digit with its anode (all off if blank)
  always_comb begin
    seg_d = dec_seg;
    an_d  = ~(4'b0001 << idx_q);
    if (state == INIT) begin
      seg_d = SEG_DASH;
    end else if (digit_blank) begin
      an_d  = 4'hF;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_score_seg_display.sv
// Directed bench for score_seg_display with SCAN_DIV=4, BLINK_DIV=8, BLINK_COUNT=4.
// cyc counts posedges since reset release; after edge k the displayed slot is ((k-1)/4)%4.
module tb_score_seg_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state = 3'd5;
  logic [3:0] score_r = 4'd0;
  logic [3:0] score_l = 4'd0;
  logic [7:0] seg;
  logic [3:0] an;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  score_seg_display #(.SCAN_DIV(4), .BLINK_DIV(8), .BLINK_COUNT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .score_r (score_r),
    .score_l (score_l),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Advance to the negedge following edge k
  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < k) begin
      n_cmp++; n_err++;
      $display("FAIL wait_timeout cyc=%0d want %0d", cyc, k);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      n_err++;
      $display("FAIL reset seg=%h an=%h want FF/F", seg, an);
    end
    rst = 1'b0;
  endtask

  task automatic test_init_dash();
    logic [3:0] an_tab [4];
    an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
    for (int k = 1; k <= 16; k++) begin
      wait_cyc(k);
      n_cmp++;
      if (seg !== 8'hBF || an !== an_tab[(k-1)/4]) begin
        n_err++;
        $display("FAIL init_dash @%0d seg=%h an=%h want BF/%h", k, seg, an, an_tab[(k-1)/4]);
      end
    end
  endtask

  task automatic test_digits();
    int         cy [6];
    logic [7:0] sg [6];
    logic [3:0] ae [6];
    cy = '{18, 22, 26, 30, 34, 36};
    sg = '{8'hC0, 8'hFF, 8'hC0, 8'hFF, 8'hA4, 8'hA4};
    ae = '{4'hE, 4'hF, 4'hB, 4'hF, 4'hE, 4'hE};
    wait_cyc(16);
    state = 3'd4; score_l = 4'd3; score_r = 4'd12;
    for (int i = 0; i < 6; i++) begin
      wait_cyc(cy[i]);
      n_cmp++;
      if (seg !== sg[i] || an !== ae[i]) begin
        n_err++;
        $display("FAIL digits @%0d seg=%h an=%h want %h/%h", cy[i], seg, an, sg[i], ae[i]);
      end
    end
  endtask

  task automatic test_shadow();
    int         cy [8];
    logic [7:0] sg [8];
    logic [3:0] ae [8];
    cy = '{38, 42, 46, 50, 54, 58, 62, 66};
    sg = '{8'hF9, 8'hB0, 8'hFF, 8'hF8, 8'hFF, 8'h90, 8'hFF, 8'h99};
    ae = '{4'hD, 4'hB, 4'hF, 4'hE, 4'hF, 4'hB, 4'hF, 4'hE};
    wait_cyc(37);
    score_r = 4'd7; score_l = 4'd9;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(cy[i]);
      n_cmp++;
      if (seg !== sg[i] || an !== ae[i]) begin
        n_err++;
        $display("FAIL shadow @%0d seg=%h an=%h want %h/%h", cy[i], seg, an, sg[i], ae[i]);
      end
      if (cy[i] == 58) begin
        score_r = 4'd14; score_l = 4'd10;
      end
    end
  endtask

  task automatic test_blink_r();
    int         cy [11];
    logic [7:0] sg [11];
    logic [3:0] ae [11];
    cy = '{74, 78, 81, 86, 88, 90, 94, 97, 102, 104, 114};
    sg = '{8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'h99};
    ae = '{4'hB, 4'h7, 4'hF, 4'hF, 4'hF, 4'hB, 4'h7, 4'hF, 4'hF, 4'hF, 4'hE};
    wait_cyc(70); state = 3'd0;
    wait_cyc(71); state = 3'd2;
    for (int i = 0; i < 11; i++) begin
      wait_cyc(cy[i]);
      n_cmp++;
      if (seg !== sg[i] || an !== ae[i]) begin
        n_err++;
        $display("FAIL blink_r @%0d seg=%h an=%h want %h/%h", cy[i], seg, an, sg[i], ae[i]);
      end
    end
    state = 3'd4;
  endtask

  task automatic test_blink_switch();
    int         cy [9];
    logic [7:0] sg [9];
    logic [3:0] ae [9];
    cy = '{127, 128, 130, 134, 137, 142, 144, 145, 150};
    sg = '{8'hF9, 8'hF9, 8'h99, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hF9};
    ae = '{4'h7, 4'h7, 4'hE, 4'hD, 4'hF, 4'hF, 4'hF, 4'hE, 4'hD};
    wait_cyc(116); state = 3'd0;
    wait_cyc(117); state = 3'd2;
    for (int i = 0; i < 9; i++) begin
      wait_cyc(cy[i]);
      n_cmp++;
      if (seg !== sg[i] || an !== ae[i]) begin
        n_err++;
        $display("FAIL blink_switch @%0d seg=%h an=%h want %h/%h", cy[i], seg, an, sg[i], ae[i]);
      end
      if (cy[i] == 127) state = 3'd3;
    end
  endtask

  task automatic test_reset_mid_blink();
    int         cy [7];
    logic [7:0] sg [7];
    logic [3:0] ae [7];
    cy = '{2, 6, 10, 14, 18, 26, 30};
    sg = '{8'hC0, 8'hFF, 8'hC0, 8'hFF, 8'h99, 8'hC0, 8'hF9};
    ae = '{4'hE, 4'hF, 4'hB, 4'hF, 4'hE, 4'hB, 4'h7};
    wait_cyc(154);
    rst = 1'b1; state = 3'd4;
    @(negedge clk);
    n_cmp++;
    if (seg !== 8'hFF || an !== 4'hF) begin
      n_err++;
      $display("FAIL reset_mid_blink seg=%h an=%h want FF/F", seg, an);
    end
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wait_cyc(cy[i]);
      n_cmp++;
      if (seg !== sg[i] || an !== ae[i]) begin
        n_err++;
        $display("FAIL after_reset @%0d seg=%h an=%h want %h/%h", cy[i], seg, an, sg[i], ae[i]);
      end
    end
  endtask

  task automatic test_init_override();
    int         cy [5];
    logic [7:0] sg [5];
    logic [3:0] ae [5];
    cy = '{39, 42, 50, 52, 54};
    sg = '{8'hBF, 8'hC0, 8'h99, 8'h99, 8'hF9};
    ae = '{4'hD, 4'hB, 4'hE, 4'hE, 4'hD};
    wait_cyc(33); state = 3'd2;
    wait_cyc(38); state = 3'd5;
    for (int i = 0; i < 5; i++) begin
      wait_cyc(cy[i]);
      n_cmp++;
      if (seg !== sg[i] || an !== ae[i]) begin
        n_err++;
        $display("FAIL init_override @%0d seg=%h an=%h want %h/%h", cy[i], seg, an, sg[i], ae[i]);
      end
      if (cy[i] == 39) begin
        wait_cyc(40);
        state = 3'd4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_dash();
    test_digits();
    test_shadow();
    test_blink_r();
    test_blink_switch();
    test_reset_mid_blink();
    test_init_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
